// File: rtl/apb_pkg.sv
// Shared types, width defaults and address decode helper for the APB slave memory.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_WAIT_W = 4;

    // Widened to 64 bits so base + span cannot overflow near the top of the map.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] span);
        return (addr >= base) && (addr < base + span);
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down counter: loaded at setup, decremented per access edge, never wraps.
module apb_wait_counter #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    input  logic [WAIT_W-1:0] load_val,
    output logic              done
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that sees one remaining wait raises Pready for the following cycle.
    assign done = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// APB responder backed by a word-addressed register array, with programmable wait
// states, out-of-range error response and a sticky protocol-violation flag.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                 DATA_W    = APB_DATA_W,
    parameter int                 ADDR_W    = APB_ADDR_W,
    parameter int                 DEPTH     = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 WAIT_W    = APB_WAIT_W
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic              Psel,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [ADDR_W-1:0] Paddr,
    input  logic [DATA_W-1:0] Pdata,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic [DATA_W-1:0] Prdata,
    output logic              Pready,
    output logic              Pslverr,
    output logic              proto_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic               proto_err_q, proto_err_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];

    logic               setup, idle_viol, abort, complete, waiting, cnt_done;
    logic               setup_err;
    logic [IDX_W-1:0]   setup_idx;

    assign setup     = (state_q == IDLE) && Psel && !Penable;
    assign idle_viol = (state_q == IDLE) && Penable;
    assign abort     = (state_q == ACCESS) && !pready_q && !Psel;
    assign waiting   = (state_q == ACCESS) && !pready_q && Psel;
    assign complete  = (state_q == ACCESS) && pready_q && Psel && Penable;

    assign setup_err = !addr_in_range(64'(Paddr), 64'(BASE_ADDR), 64'(DEPTH) * 64'd4);
    assign setup_idx = IDX_W'((Paddr - BASE_ADDR) >> 2);

    apb_wait_counter #(.WAIT_W(WAIT_W)) u_wait_counter (
        .clk      (Pclk),
        .rst      (Preset),
        .load     (setup),
        .dec      (waiting),
        .load_val (wait_cfg),
        .done     (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS:  if (complete || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        wr_d        = wr_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        prdata_d    = prdata_q;
        pready_d    = pready_q;
        pslverr_d   = pslverr_q;
        proto_err_d = proto_err_q || idle_viol || abort;
        mem_d       = mem_q;

        if (setup) begin
            idx_d   = setup_idx;
            wr_d    = Pwrite;
            err_d   = setup_err;
            wdata_d = Pdata;
            if (wait_cfg == '0) begin
                pready_d  = 1'b1;
                pslverr_d = setup_err;
                if (!Pwrite) prdata_d = setup_err ? '0 : mem_q[setup_idx];
            end
        end

        if (waiting && cnt_done) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!wr_q) prdata_d = err_q ? '0 : mem_q[idx_q];
        end

        if (complete) begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            if (wr_q && !err_q) mem_d[idx_q] = wdata_q;
        end

        if (abort) begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
        end
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            proto_err_q <= proto_err_d;
            mem_q       <= mem_d;
        end
    end

    assign Prdata    = prdata_q;
    assign Pready    = pready_q;
    assign Pslverr   = pslverr_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomised bench for apb_slave_mem against a transaction-level memory model.
module tb_apb_slave_mem;

    logic        Pclk = 1'b0;
    logic        Preset = 1'b0;
    logic        Psel = 1'b0;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = '0;
    logic [31:0] Pdata = '0;
    logic [3:0]  wait_cfg = '0;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic        proto_err;

    apb_slave_mem dut (
        .Pclk      (Pclk),
        .Preset    (Preset),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pdata     (Pdata),
        .wait_cfg  (wait_cfg),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .proto_err (proto_err)
    );

    always #5 Pclk = ~Pclk;

    int unsigned model_mem [64];
    logic        exp_pready = 1'b0;
    logic        exp_pslverr = 1'b0;
    logic [31:0] exp_prdata = '0;
    logic        exp_proto = 1'b0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          last_rk;
    logic        last_slv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Pclk) begin
        if (chk_en) begin
            chk("pready",    32'(Pready),    32'(exp_pready));
            chk("pslverr",   32'(Pslverr),   32'(exp_pslverr));
            chk("prdata",    Prdata,         exp_prdata);
            chk("proto_err", 32'(proto_err), 32'(exp_proto));
        end
    end

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic idle();
        Psel = 1'b0;
        Penable = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_mem[i] = 0;
        exp_pready = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata = '0;
        exp_proto = 1'b0;
    endtask

    // One complete transfer; access-phase inputs are scrambled since they must be ignored.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input int w, input bit gap);
        bit err;
        int idx;
        err = (addr >= 32'h100);
        idx = int'((addr >> 2) & 32'h3f);
        Psel = 1'b1;
        Penable = 1'b0;
        Pwrite = wr;
        Paddr = addr;
        Pdata = data;
        wait_cfg = 4'(w);
        exp_pready = 1'b0;
        exp_pslverr = 1'b0;
        tick();
        last_rk = 0;
        last_slv = 1'b0;
        for (int k = 1; k <= w + 1; k++) begin
            Penable = 1'b1;
            Paddr = $urandom;
            Pdata = $urandom;
            Pwrite = 1'($urandom);
            wait_cfg = 4'($urandom);
            if (k == w + 1) begin
                exp_pready = 1'b1;
                exp_pslverr = err;
                if (!wr) exp_prdata = err ? 32'h0 : model_mem[idx];
            end
            if (Pready === 1'b1 && last_rk == 0) begin
                last_rk = k;
                last_slv = Pslverr;
            end
            tick();
        end
        if (wr && !err) model_mem[idx] = data;
        exp_pready = 1'b0;
        exp_pslverr = 1'b0;
        if (gap) idle();
    endtask

    initial begin
        model_reset();
        #1 Preset = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        Preset = 1'b0;
        chk("reset_prdata", Prdata, 32'h0);
        chk("reset_pready", 32'(Pready), 32'h0);
        chk("reset_proto",  32'(proto_err), 32'h0);
        idle();

        // Zero-wait write then read
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b1);
        chk("wr0_ready_cycle", 32'(last_rk), 32'd1);
        xfer(1'b0, 32'h10, 32'h0, 0, 1'b1);
        chk("rd0_ready_cycle", 32'(last_rk), 32'd1);
        chk("rd0_data", Prdata, 32'hDEAD_BEEF);
        chk("rd0_slverr", 32'(last_slv), 32'h0);

        // Three wait states
        xfer(1'b0, 32'h10, 32'h0, 3, 1'b1);
        chk("rd3_ready_cycle", 32'(last_rk), 32'd4);
        chk("rd3_data", Prdata, 32'hDEAD_BEEF);

        // Back-to-back writes and reads
        xfer(1'b1, 32'h0, 32'h1111_1111, 1, 1'b0);
        xfer(1'b1, 32'h4, 32'h2222_2222, 0, 1'b0);
        xfer(1'b1, 32'h8, 32'h3333_3333, 2, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 0, 1'b0);
        chk("b2b_rd0", Prdata, 32'h1111_1111);
        xfer(1'b0, 32'h4, 32'h0, 2, 1'b0);
        chk("b2b_rd4", Prdata, 32'h2222_2222);
        xfer(1'b0, 32'hB, 32'h0, 1, 1'b1);
        chk("b2b_rd8_unaligned", Prdata, 32'h3333_3333);

        // Out-of-range accesses
        xfer(1'b1, 32'h100, 32'hAAAA_AAAA, 0, 1'b1);
        chk("oor_wr_slverr", 32'(last_slv), 32'h1);
        xfer(1'b0, 32'h0, 32'h0, 0, 1'b1);
        chk("oor_word0_kept", Prdata, 32'h1111_1111);
        xfer(1'b0, 32'h100, 32'h0, 2, 1'b1);
        chk("oor_rd_data", Prdata, 32'h0);
        chk("oor_rd_slverr", 32'(last_slv), 32'h1);

        // Protocol violations: Penable in IDLE, then Psel dropped mid-wait
        Psel = 1'b0;
        Penable = 1'b1;
        tick();
        exp_proto = 1'b1;
        Penable = 1'b0;
        tick();
        chk("proto_idle_enable", 32'(proto_err), 32'h1);
        Psel = 1'b1;
        Pwrite = 1'b1;
        Paddr = 32'h0;
        Pdata = 32'h5555_5555;
        wait_cfg = 4'd5;
        tick();
        Penable = 1'b1;
        tick();
        tick();
        Psel = 1'b0;
        Penable = 1'b0;
        tick();
        idle();
        xfer(1'b0, 32'h0, 32'h0, 0, 1'b1);
        chk("abort_no_write", Prdata, 32'h1111_1111);
        chk("proto_sticky", 32'(proto_err), 32'h1);

        // Asynchronous reset during the wait phase of a write
        Psel = 1'b1;
        Penable = 1'b0;
        Pwrite = 1'b1;
        Paddr = 32'h10;
        Pdata = 32'h7777_7777;
        wait_cfg = 4'd5;
        tick();
        Penable = 1'b1;
        tick();
        #2 Preset = 1'b1;
        model_reset();
        Psel = 1'b0;
        Penable = 1'b0;
        #1;
        chk("rst_async_prdata", Prdata, 32'h0);
        chk("rst_async_proto", 32'(proto_err), 32'h0);
        chk("rst_async_pready", 32'(Pready), 32'h0);
        tick();
        Preset = 1'b0;
        idle();
        xfer(1'b0, 32'h10, 32'h0, 1, 1'b1);
        chk("rst_word_cleared", Prdata, 32'h0);
        chk("rst_rd_slverr", 32'(last_slv), 32'h0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 300));
            xfer(1'($urandom), a, $urandom, int'($urandom_range(0, 7)), 1'($urandom));
        end
        idle();
        idle();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
